// File: rtl/sha256_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : sha256_run_ctrl
// Description : Single-block SHA256 run sequencer. Accepts a host start,
//               pulses the padding generator, waits for the padded block,
//               pulses the compression core, then writes the 256-bit digest
//               to output SRAM as eight 32-bit words (H0 first).
//               Optional per-wait-state watchdog: define CTRL_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module sha256_run_ctrl #(
    parameter int         MAX_LEN        = 55,
    parameter logic [3:0] OUT_BASE       = 4'd0,
    parameter int         TIMEOUT_CYCLES = 1023
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         start,
    input  logic [5:0]   msg_len,
    input  logic         pad_rdy,
    input  logic         core_done,
    input  logic [255:0] digest,
    output logic         pad_go,
    output logic [5:0]   pad_len,
    output logic         core_start,
    output logic         out_mem_we,
    output logic [3:0]   out_mem_addr,
    output logic [31:0]  out_mem_data,
    output logic         busy,
    output logic         done,
    output logic         err
);

    localparam logic [5:0] c_max_len = 6'(MAX_LEN);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_PAD_GO    = 3'd1,
        S_PAD_CLR   = 3'd2,
        S_PAD_WAIT  = 3'd3,
        S_CORE_GO   = 3'd4,
        S_CORE_WAIT = 3'd5,
        S_WRITE     = 3'd6,
        S_FIN       = 3'd7
    } state_t;

    state_t         r_state;
    state_t         w_state_next;
    logic [2:0]     r_cnt;
    logic [2:0]     w_cnt_next;
    logic [255:0]   r_digest;
    logic [255:0]   w_digest_next;
    logic           w_err_next;
    logic           w_accept;
    logic           w_write_next;

`ifdef CTRL_TIMEOUT_EN
    localparam int c_tmo_w = ($clog2(TIMEOUT_CYCLES + 1) < 10) ? 10 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_tmo_w-1:0] c_tmo_last = c_tmo_w'(TIMEOUT_CYCLES - 1);

    logic [c_tmo_w-1:0] r_tmo;
    logic               w_waiting;

    assign w_waiting = (r_state == S_PAD_CLR) || (r_state == S_PAD_WAIT) ||
                       (r_state == S_CORE_WAIT);

    // Watchdog: restarts on every state change, counts cycles spent waiting
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_tmo <= '0;
        end else if (w_state_next != r_state) begin
            r_tmo <= '0;
        end else if (w_waiting) begin
            r_tmo <= r_tmo + 1'b1;
        end
    end
`endif

    // State, word counter and digest latch
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_digest <= '0;
        end else begin
            r_state  <= w_state_next;
            r_cnt    <= w_cnt_next;
            r_digest <= w_digest_next;
        end
    end

    // Next-state decode; a length violation is reported without leaving IDLE
    always_comb begin
        w_state_next  = r_state;
        w_cnt_next    = r_cnt;
        w_digest_next = r_digest;
        w_err_next    = 1'b0;
        w_accept      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    if (msg_len > c_max_len) begin
                        w_err_next = 1'b1;
                    end else begin
                        w_accept     = 1'b1;
                        w_state_next = S_PAD_GO;
                    end
                end
            end
            S_PAD_GO:   w_state_next = S_PAD_CLR;
            // A stale ready level from the previous run must drop first
            S_PAD_CLR:  if (!pad_rdy) w_state_next = S_PAD_WAIT;
            S_PAD_WAIT: if (pad_rdy)  w_state_next = S_CORE_GO;
            S_CORE_GO:  w_state_next = S_CORE_WAIT;
            S_CORE_WAIT: begin
                if (core_done) begin
                    w_digest_next = digest;
                    w_cnt_next    = 3'd0;
                    w_state_next  = S_WRITE;
                end
            end
            S_WRITE: begin
                if (r_cnt == 3'd7) begin
                    w_state_next = S_FIN;
                end else begin
                    w_cnt_next = r_cnt + 3'd1;
                end
            end
            S_FIN:   w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
`ifdef CTRL_TIMEOUT_EN
        if (w_waiting && (w_state_next == r_state) && (r_tmo == c_tmo_last)) begin
            w_state_next = S_IDLE;
            w_err_next   = 1'b1;
        end
`endif
    end

    assign w_write_next = (w_state_next == S_WRITE);

    // Registered outputs, derived from the state being entered
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            pad_go       <= 1'b0;
            pad_len      <= '0;
            core_start   <= 1'b0;
            out_mem_we   <= 1'b0;
            out_mem_addr <= '0;
            out_mem_data <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
        end else begin
            pad_go       <= (w_state_next == S_PAD_GO);
            core_start   <= (w_state_next == S_CORE_GO);
            out_mem_we   <= w_write_next;
            out_mem_addr <= w_write_next ? (OUT_BASE + {1'b0, w_cnt_next}) : 4'd0;
            // Word k is digest[255-32k -: 32]; ~k equals 7-k for a 3-bit count
            out_mem_data <= w_write_next ? w_digest_next[{~w_cnt_next, 5'd0} +: 32] : 32'd0;
            busy         <= (w_state_next != S_IDLE) && (w_state_next != S_FIN);
            done         <= (w_state_next == S_FIN);
            err          <= w_err_next;
            if (w_accept) begin
                pad_len <= msg_len;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sha256_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_sha256_run_ctrl
// Description : Self-checking bench for sha256_run_ctrl. Each run builds
//               per-cycle input waveforms, derives expected output timing
//               from the sequencing rules, then drives and compares.
//               Timeout scenario compiled only with CTRL_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sha256_run_ctrl;

    localparam logic [3:0] OUT_BASE = 4'd12;
    localparam int         TMO      = 20;
    localparam int         N        = 64;

    logic         clock = 1'b0;
    logic         reset_n = 1'b0;
    logic         start = 1'b0;
    logic [5:0]   msg_len = '0;
    logic         pad_rdy = 1'b0;
    logic         core_done = 1'b0;
    logic [255:0] digest = '0;
    logic         pad_go, core_start, out_mem_we, busy, done, err;
    logic [5:0]   pad_len;
    logic [3:0]   out_mem_addr;
    logic [31:0]  out_mem_data;

    int           errors = 0;
    int           checks = 0;
    logic [5:0]   exp_pad_len = '0;
    bit           pad_len_known = 1'b1;

    sha256_run_ctrl #(
        .MAX_LEN        (55),
        .OUT_BASE       (OUT_BASE),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .start        (start),
        .msg_len      (msg_len),
        .pad_rdy      (pad_rdy),
        .core_done    (core_done),
        .digest       (digest),
        .pad_go       (pad_go),
        .pad_len      (pad_len),
        .core_start   (core_start),
        .out_mem_we   (out_mem_we),
        .out_mem_addr (out_mem_addr),
        .out_mem_data (out_mem_data),
        .busy         (busy),
        .done         (done),
        .err          (err)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input int n, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, n, obs, exp);
        end
    endtask

    task automatic chk_zero(input int n);
        chk("rst_pad_go", n, 32'(pad_go), 32'd0);
        chk("rst_pad_len", n, 32'(pad_len), 32'd0);
        chk("rst_core_start", n, 32'(core_start), 32'd0);
        chk("rst_we", n, 32'(out_mem_we), 32'd0);
        chk("rst_addr", n, 32'(out_mem_addr), 32'd0);
        chk("rst_data", n, out_mem_data, 32'd0);
        chk("rst_busy", n, 32'(busy), 32'd0);
        chk("rst_done", n, 32'(done), 32'd0);
        chk("rst_err", n, 32'(err), 32'd0);
    endtask

    function automatic logic [255:0] rnd_digest();
        logic [255:0] d;
        for (int k = 0; k < 8; k++) d[32*k +: 32] = $urandom();
        return d;
    endfunction

    // mode 0: pad_rdy rises pd cycles after pad_go; mode 1: pad_rdy still high
    // from a previous run; mode 2: core_done never arrives (watchdog).
    // rst_wr >= 0 asserts reset during write word rst_wr.
    task automatic run(input logic [5:0] len, input logic [255:0] dg, input int mode,
                       input int pd, input int cd, input int rst_wr);
        logic         r   [N];
        logic         cdn [N];
        logic         st  [N];
        logic [255:0] dv  [N];
        int i, j, cs, c, last, h, z, rst_at, k;
        logic e_we, e_busy, e_done, e_err;
        for (int n = 0; n < N; n++) begin
            r[n] = 1'b0; cdn[n] = 1'b0; st[n] = 1'b0; dv[n] = rnd_digest();
        end
        h = $urandom_range(0, 4);
        z = $urandom_range(1, 3);
        for (int n = 0; n < N; n++) begin
            if (mode == 1) r[n] = (n <= 1 + h) || (n > 1 + h + z);
            else           r[n] = (n >= 1 + pd);
        end
        // PAD_CLR occupies cycle 2 onward until ready is seen low; PAD_WAIT follows
        i = 2;
        while (r[i]) i++;
        j = i + 1;
        while (!r[j]) j++;
        cs = j + 1;
        for (int n = 0; n <= cs; n++) cdn[n] = 1'($urandom_range(0, 1));
        if (mode == 2) begin
            c    = N;
            last = cs + 1 + TMO;
        end else begin
            c = cs + 1 + cd;
            cdn[c] = 1'b1;
            dv[c]  = dg;
            for (int n = c + 1; n <= c + 9; n++) cdn[n] = 1'($urandom_range(0, 1));
            last = c + 9;
        end
        st[0] = 1'b1;
        for (int n = 1; n <= ((mode == 2) ? last - 1 : last); n++) st[n] = 1'($urandom_range(0, 1));
        rst_at = (rst_wr >= 0 && mode != 2) ? c + 1 + rst_wr : -1;

        for (int n = 0; n <= last; n++) begin
            start     = st[n];
            msg_len   = (n == 0) ? len : 6'($urandom_range(0, 63));
            pad_rdy   = r[n];
            core_done = cdn[n];
            digest    = dv[n];
            if (mode == 2) begin
                e_we = 1'b0; e_done = 1'b0;
                e_busy = (n >= 1) && (n <= cs + TMO);
                e_err  = (n == cs + 1 + TMO);
            end else begin
                e_we   = (n > c) && (n <= c + 8);
                e_done = (n == c + 9);
                e_busy = (n >= 1) && (n <= c + 8);
                e_err  = 1'b0;
            end
            chk("pad_go", n, 32'(pad_go), 32'(n == 1));
            chk("core_start", n, 32'(core_start), 32'(n == cs));
            chk("we", n, 32'(out_mem_we), 32'(e_we));
            chk("busy", n, 32'(busy), 32'(e_busy));
            chk("done", n, 32'(done), 32'(e_done));
            chk("err", n, 32'(err), 32'(e_err));
            if (n == 0) begin
                if (pad_len_known) chk("pad_len_hold", n, 32'(pad_len), 32'(exp_pad_len));
                exp_pad_len   = len;
                pad_len_known = 1'b1;
            end else begin
                chk("pad_len", n, 32'(pad_len), 32'(len));
            end
            if (e_we) begin
                k = n - c - 1;
                chk("addr", n, 32'(out_mem_addr), 32'(4'(OUT_BASE + 4'(k))));
                chk("data", n, out_mem_data, dg[255 - 32*k -: 32]);
            end
            if (n == rst_at) begin
                reset_n = 1'b0;
                step(); start = 1'b0; core_done = 1'b0; chk_zero(n + 1);
                step(); chk_zero(n + 2);
                reset_n = 1'b1;
                step(); chk_zero(n + 3);
                exp_pad_len = '0;
                return;
            end
            step();
        end
    endtask

    // Over-length request: err next cycle, no launch, busy stays low
    task automatic err_run(input logic [5:0] len);
        start = 1'b1; msg_len = len;
        chk("len_busy0", 0, 32'(busy), 32'd0);
        step();
        start = 1'b0; msg_len = 6'($urandom_range(0, 63));
        chk("len_err", 1, 32'(err), 32'd1);
        chk("len_busy", 1, 32'(busy), 32'd0);
        chk("len_pad_go", 1, 32'(pad_go), 32'd0);
        step();
        chk("len_err_clr", 2, 32'(err), 32'd0);
        pad_len_known = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0;
        step(); chk_zero(0);
        step(); chk_zero(1);
        reset_n = 1'b1;
        step();
        run(6'd3, 256'hBA7816BF_8F01CFEA_414140DE_5DAE2223_B00361A3_96177A9C_B410FF61_F20015AD,
            0, 6, 3, -1);
        run(6'd55, rnd_digest(), 1, 0, 2, -1);
        err_run(6'd56);
        run(6'd0, rnd_digest(), 0, 3, 0, -1);
        run(6'd20, rnd_digest(), 1, 0, 1, 3);
        run(6'($urandom_range(0, 55)), rnd_digest(), 0, 4, 5, -1);
        err_run(6'($urandom_range(57, 63)));
        for (int t = 0; t < 6; t++) begin
            run(6'($urandom_range(0, 55)), rnd_digest(), int'($urandom_range(0, 1)),
                int'($urandom_range(2, 8)), int'($urandom_range(0, 10)), -1);
        end
`ifdef CTRL_TIMEOUT_EN
        run(6'd10, rnd_digest(), 2, 3, 0, -1);
        run(6'($urandom_range(0, 55)), rnd_digest(), 0, 2, 1, -1);
`endif
        start = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
